adder4b_operand_seq: RTL and testbench

//  Operand sequencer directly upstream of the team's combinational 4-bit adder.

---
 rtl/adder4b_operand_seq_if.sv | 27 ++
 rtl/adder4b_operand_seq.sv | 128 ++++++++++++
 tb/tb_adder4b_operand_seq.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/adder4b_operand_seq_if.sv
// Bus between the operand sequencer and the external combinational adder.
// The sequencer drives the operands; the adder returns sum and carry.
interface adder4b_operand_seq_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             ci_out;
    logic [WIDTH-1:0] s_in;
    logic             co_in;

    modport master (
        output a_out,
        output b_out,
        output ci_out,
        input  s_in,
        input  co_in
    );

    modport slave (
        input  a_out,
        input  b_out,
        input  ci_out,
        output s_in,
        output co_in
    );
endinterface

// File: rtl/adder4b_operand_seq.sv
// Captures A, then B and Ci, on "enter" button presses, feeds them to the external
// adder, and registers the adder result for display. Optional accumulate mode.
module adder4b_operand_seq #(
    parameter int unsigned WIDTH    = 4,
    parameter bit          ACC_MODE = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enter,
    input  logic [WIDTH-1:0]      din,
    input  logic                  cin_sw,
    adder4b_operand_seq_if.master adder,
    output logic [WIDTH-1:0]      sum,
    output logic                  cout,
    output logic                  valid,
    output logic [1:0]            state
);

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        SETTLE = 2'b10,
        SHOW   = 2'b11
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             ci_q, ci_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             valid_q, valid_d;
    logic             enter_q;
    logic             ev;

    // One-cycle event per press; enter_q resets high so a button held through reset is ignored
    assign ev = enter & ~enter_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            ci_q    <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
            enter_q <= 1'b1;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ci_q    <= ci_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            valid_q <= valid_d;
            enter_q <= enter;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = LOAD_A;
        end else begin
            case (state_q)
                LOAD_A: if (ev) state_d = LOAD_B;
                LOAD_B: if (ev) state_d = SETTLE;
                SETTLE: state_d = SHOW;
                SHOW:   if (ev) state_d = ACC_MODE ? LOAD_B : LOAD_A;
                default: state_d = LOAD_A;
            endcase
        end
    end

    // Datapath updates; clear wins over any coincident press
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        ci_d    = ci_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        valid_d = valid_q;
        if (clear) begin
            a_d     = '0;
            b_d     = '0;
            ci_d    = 1'b0;
            sum_d   = '0;
            cout_d  = 1'b0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (ev) a_d = din;
                end
                LOAD_B: begin
                    if (ev) begin
                        b_d  = din;
                        ci_d = cin_sw;
                    end
                end
                SETTLE: begin
                    sum_d   = adder.s_in;
                    cout_d  = adder.co_in;
                    valid_d = 1'b1;
                end
                SHOW: begin
                    if (ev) begin
                        valid_d = 1'b0;
                        // Accumulate chains only the sum; the carry out is dropped
                        if (ACC_MODE) a_d = sum_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign adder.a_out  = a_q;
    assign adder.b_out  = b_q;
    assign adder.ci_out = ci_q;
    assign sum          = sum_q;
    assign cout         = cout_q;
    assign valid        = valid_q;
    assign state        = state_q;

endmodule

// File: tb/tb_adder4b_operand_seq.sv
// Directed bench: two sequencers (plain and accumulate mode) each feeding a 4-bit adder model.
module tb_adder4b_operand_seq;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic       enter0 = 1'b1;
    logic       enter1 = 1'b1;
    logic [3:0] din = 4'h0;
    logic       cin_sw = 1'b0;

    logic [3:0] sum0, sum1;
    logic       cout0, cout1, valid0, valid1;
    logic [1:0] state0, state1;

    int ncmp = 0;
    int nerr = 0;

    always #5 clock = ~clock;

    adder4b_operand_seq_if #(.WIDTH(4)) bus0 ();
    adder4b_operand_seq_if #(.WIDTH(4)) bus1 ();

    assign {bus0.co_in, bus0.s_in} = 5'(bus0.a_out) + 5'(bus0.b_out) + 5'(bus0.ci_out);
    assign {bus1.co_in, bus1.s_in} = 5'(bus1.a_out) + 5'(bus1.b_out) + 5'(bus1.ci_out);

    adder4b_operand_seq #(.WIDTH(4), .ACC_MODE(1'b0)) dut0 (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .enter (enter0),
        .din   (din),
        .cin_sw(cin_sw),
        .adder (bus0.master),
        .sum   (sum0),
        .cout  (cout0),
        .valid (valid0),
        .state (state0)
    );

    adder4b_operand_seq #(.WIDTH(4), .ACC_MODE(1'b1)) dut1 (
        .clock (clock),
        .reset (reset),
        .clear (clear),
        .enter (enter1),
        .din   (din),
        .cin_sw(cin_sw),
        .adder (bus1.master),
        .sum   (sum1),
        .cout  (cout1),
        .valid (valid1),
        .state (state1)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Release, then press once; outputs are checked just after the capturing edge
    task automatic press0(input logic [3:0] d, input logic c);
        enter0 = 1'b0;
        tick();
        din    = d;
        cin_sw = c;
        enter0 = 1'b1;
        tick();
        enter0 = 1'b0;
    endtask

    task automatic press1(input logic [3:0] d, input logic c);
        enter1 = 1'b0;
        tick();
        din    = d;
        cin_sw = c;
        enter1 = 1'b1;
        tick();
        enter1 = 1'b0;
    endtask

    task automatic chk0(input string tag, input logic [1:0] st, input logic [3:0] a,
                        input logic [3:0] b, input logic ci, input logic [3:0] s,
                        input logic co, input logic v);
        chk({tag, ".state"}, 32'(state0), 32'(st));
        chk({tag, ".a_out"}, 32'(bus0.a_out), 32'(a));
        chk({tag, ".b_out"}, 32'(bus0.b_out), 32'(b));
        chk({tag, ".ci_out"}, 32'(bus0.ci_out), 32'(ci));
        chk({tag, ".sum"}, 32'(sum0), 32'(s));
        chk({tag, ".cout"}, 32'(cout0), 32'(co));
        chk({tag, ".valid"}, 32'(valid0), 32'(v));
    endtask

    task automatic chk1(input string tag, input logic [1:0] st, input logic [3:0] a,
                        input logic [3:0] b, input logic ci, input logic [3:0] s,
                        input logic co, input logic v);
        chk({tag, ".state"}, 32'(state1), 32'(st));
        chk({tag, ".a_out"}, 32'(bus1.a_out), 32'(a));
        chk({tag, ".b_out"}, 32'(bus1.b_out), 32'(b));
        chk({tag, ".ci_out"}, 32'(bus1.ci_out), 32'(ci));
        chk({tag, ".sum"}, 32'(sum1), 32'(s));
        chk({tag, ".cout"}, 32'(cout1), 32'(co));
        chk({tag, ".valid"}, 32'(valid1), 32'(v));
    endtask

    initial begin
        // Reset with both buttons held; holding through release must not capture
        din = 4'h9;
        tick();
        tick();
        chk0("rst0", 2'b00, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        chk1("rst1", 2'b00, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (5) tick();
        chk0("held0", 2'b00, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        chk1("held1", 2'b00, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        enter1 = 1'b0;

        // 1110 + 1100 + 1 = 1_1011
        press0(4'hE, 1'b0);
        chk0("capA", 2'b01, 4'hE, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        press0(4'hC, 1'b1);
        chk0("capB", 2'b10, 4'hE, 4'hC, 1'b1, 4'h0, 1'b0, 1'b0);
        tick();
        chk0("res1", 2'b11, 4'hE, 4'hC, 1'b1, 4'hB, 1'b1, 1'b1);
        repeat (3) tick();
        chk0("hold1", 2'b11, 4'hE, 4'hC, 1'b1, 4'hB, 1'b1, 1'b1);
        press0(4'h0, 1'b0);
        chk0("leave1", 2'b00, 4'hE, 4'hC, 1'b1, 4'hB, 1'b1, 1'b0);

        // 1111 + 1111 + 1 = 1_1111
        press0(4'hF, 1'b0);
        press0(4'hF, 1'b1);
        tick();
        chk0("res2", 2'b11, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b1);
        press0(4'h0, 1'b0);

        // 0000 + 0000 + 0 = 0_0000
        press0(4'h0, 1'b0);
        press0(4'h0, 1'b0);
        tick();
        chk0("res3", 2'b11, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1);
        press0(4'h0, 1'b0);
        chk0("leave3", 2'b00, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);

        // Long hold in LOAD_A: exactly one capture of the value present at the edge
        enter0 = 1'b0;
        tick();
        din    = 4'h7;
        enter0 = 1'b1;
        tick();
        chk0("long0", 2'b01, 4'h7, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        din = 4'h9;
        repeat (9) tick();
        chk0("long9", 2'b01, 4'h7, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        enter0 = 1'b0;
        tick();

        // Accumulate: 0011 + 0010 = 0101, then 0101 + 0100 = 1001
        press1(4'h3, 1'b0);
        chk1("accA", 2'b01, 4'h3, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        press1(4'h2, 1'b0);
        tick();
        chk1("accR1", 2'b11, 4'h3, 4'h2, 1'b0, 4'h5, 1'b0, 1'b1);
        press1(4'hF, 1'b1);
        chk1("accChain", 2'b01, 4'h5, 4'h2, 1'b0, 4'h5, 1'b0, 1'b0);
        press1(4'h4, 1'b0);
        tick();
        chk1("accR2", 2'b11, 4'h5, 4'h4, 1'b0, 4'h9, 1'b0, 1'b1);

        // Clear with enter high in SETTLE: everything back to reset values
        press0(4'h5, 1'b1);
        chk0("preclr", 2'b10, 4'h7, 4'h5, 1'b1, 4'h0, 1'b0, 1'b0);
        clear  = 1'b1;
        enter0 = 1'b1;
        tick();
        chk0("clr0", 2'b00, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        chk1("clr1", 2'b00, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        clear = 1'b0;
        tick();
        chk0("postclr", 2'b00, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
        press0(4'h2, 1'b0);
        chk0("recap", 2'b01, 4'h2, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
